// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the BCD sanitising sequencer.
// Imported by the lane checker and the sequencer top.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_MAX     = 9;
    localparam int NUM_DIGITS  = 300;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/bcd_lane_check.sv
// Combinational check of LANES packed BCD digits: sanitise, flag,
// count and locate the lowest invalid digit.
module bcd_lane_check #(
    parameter int LANES = 20,
    parameter int CL    = $clog2(LANES + 1),
    parameter int IW    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic [4*LANES-1:0] dig,
    output logic [4*LANES-1:0] san,
    output logic [LANES-1:0]   mask,
    output logic [CL-1:0]      cnt,
    output logic [IW-1:0]      first,
    output logic               any
);
    import bcd_pkg::*;

    logic [BCD_DIGIT_W-1:0] d;

    // Walk high to low so the last hit left in 'first' is the lowest index.
    always_comb begin
        san   = '0;
        mask  = '0;
        cnt   = '0;
        first = '0;
        any   = 1'b0;
        d     = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            d = dig[4*i +: 4];
            if (d > 4'(BCD_MAX)) begin
                mask[i] = 1'b1;
                cnt     = cnt + CL'(1);
                first   = IW'(i);
                any     = 1'b1;
            end else begin
                san[4*i +: 4] = d;
            end
        end
    end

endmodule

// File: rtl/bcd_convert_sequencer.sv
// Streams a wide packed BCD word through a narrow lane checker, one
// beat of LANES digits per cycle, accumulating error count and first index.
module bcd_convert_sequencer #(
    parameter int NUM_DIGITS = bcd_pkg::NUM_DIGITS,
    parameter int LANES      = 20,
    parameter int CW         = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*NUM_DIGITS-1:0] in_bcd,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*NUM_DIGITS-1:0] out_dec,
    output logic [CW-1:0]           out_err_count,
    output logic [CW-1:0]           out_first_err,
    output logic                    busy
);
    import bcd_pkg::*;

    localparam int BEATS = NUM_DIGITS / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CL    = $clog2(LANES + 1);
    localparam int IW    = (LANES > 1) ? $clog2(LANES) : 1;

    seq_state_t              state;
    logic [BW-1:0]           beat;
    logic [4*NUM_DIGITS-1:0] shadow;

    logic [4*LANES-1:0] lane_dig;
    logic [4*LANES-1:0] lane_san;
    logic [LANES-1:0]   lane_mask;
    logic [CL-1:0]      lane_cnt;
    logic [IW-1:0]      lane_first;
    logic               lane_any;

    assign lane_dig = shadow[int'(beat)*4*LANES +: 4*LANES];

    bcd_lane_check #(
        .LANES (LANES),
        .CL    (CL),
        .IW    (IW)
    ) u_lane (
        .dig   (lane_dig),
        .san   (lane_san),
        .mask  (lane_mask),
        .cnt   (lane_cnt),
        .first (lane_first),
        .any   (lane_any)
    );

    // in_ready is gated by reset so a word is never taken while clearing.
    assign in_ready  = (state == IDLE) && !reset;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            beat          <= '0;
            shadow        <= '0;
            out_dec       <= '0;
            out_err_count <= '0;
            out_first_err <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        shadow        <= in_bcd;
                        out_dec       <= '0;
                        out_err_count <= '0;
                        out_first_err <= CW'(NUM_DIGITS);
                        beat          <= '0;
                        state         <= RUN;
                    end
                end
                RUN: begin
                    out_dec[int'(beat)*4*LANES +: 4*LANES] <= lane_san;
                    out_err_count <= out_err_count + CW'(lane_cnt);
                    if (out_first_err == CW'(NUM_DIGITS) && lane_any)
                        out_first_err <=
                            CW'(int'(beat) * LANES + int'(lane_first));
                    beat <= beat + BW'(1);
                    if (beat == BW'(BEATS - 1))
                        state <= DONE;
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_convert_sequencer.sv
// Scoreboard bench: driver pushes model results, negedge monitor pops
// and compares whenever the sequencer presents a result.
module tb_bcd_convert_sequencer;

    localparam int ND    = 300;
    localparam int LN    = 20;
    localparam int BEATS = ND / LN;
    localparam int W     = 4 * ND;

    typedef struct {
        logic [W-1:0] dec;
        int           cnt;
        int           first;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_bcd = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_dec;
    logic [8:0]   out_err_count;
    logic [8:0]   out_first_err;
    logic         busy;

    int   tests = 0;
    int   failed = 0;
    int   cyc = 0;
    bit   seen = 0;
    bit   rnd_ready = 0;
    exp_t q[$];

    bcd_convert_sequencer #(
        .NUM_DIGITS (ND),
        .LANES      (LN),
        .CW         (9)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_bcd        (in_bcd),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_dec       (out_dec),
        .out_err_count (out_err_count),
        .out_first_err (out_first_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk)
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0d want %0d", nm, got, exp);
        end
    endtask

    task automatic chkdec(input string nm, input logic [W-1:0] got,
                          input logic [W-1:0] exp);
        int k;
        tests++;
        if (got !== exp) begin
            failed++;
            k = 0;
            while (k < ND - 1 && got[4*k +: 4] === exp[4*k +: 4]) k++;
            $display("FAIL %s: digit %0d got %h want %h",
                     nm, k, got[4*k +: 4], exp[4*k +: 4]);
        end
    endtask

    // Reference: a digit above nine is an error and reads back as zero.
    function automatic exp_t model(input logic [W-1:0] w);
        exp_t e;
        int   d;
        e.dec = '0;
        e.cnt = 0;
        e.first = ND;
        e.acc = 0;
        for (int i = 0; i < ND; i++) begin
            d = int'(w[4*i +: 4]);
            if (d > 9) begin
                e.cnt++;
                if (e.first == ND) e.first = i;
            end else begin
                e.dec[4*i +: 4] = 4'(d);
            end
        end
        return e;
    endfunction

    function automatic logic [W-1:0] rand_word(input int pct);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < ND; i++)
            if (int'($urandom_range(0, 99)) < pct)
                w[4*i +: 4] = 4'($urandom_range(10, 15));
            else
                w[4*i +: 4] = 4'($urandom_range(0, 9));
        return w;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (out_valid && !seen) begin
            seen = 1;
            if (q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_out_valid: got 1 want 0");
            end else begin
                e = q.pop_front();
                chkdec("out_dec", out_dec, e.dec);
                chk("err_count", 64'(out_err_count), 64'(e.cnt));
                chk("first_err", 64'(out_first_err), 64'(e.first));
                chk("latency", 64'(cyc - e.acc), 64'(BEATS));
            end
        end
        if (!out_valid) seen = 0;
    end

    task automatic send(input logic [W-1:0] w);
        exp_t e;
        int   n;
        @(negedge clk);
        in_bcd   = w;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++;
            failed++;
            $display("FAIL accept_timeout: got in_ready 0 want 1");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e = model(w);
        e.acc = cyc;
        q.push_back(e);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            tests++;
            failed++;
            $display("FAIL valid_timeout: got out_valid 0 want 1");
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL drain_timeout: got %0d pending want 0", q.size());
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("in_ready_after_done", 64'(in_ready), 64'd1);
        chk("out_valid_after_done", 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [W-1:0] w;
        logic [W-1:0] w2;
        exp_t         e;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chkdec("rst_out_dec", out_dec, '0);
        chk("rst_err_count", 64'(out_err_count), 64'd0);
        chk("rst_first_err", 64'(out_first_err), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", 64'(in_ready), 64'd1);

        // All valid, digit i = i mod 10
        w = '0;
        for (int i = 0; i < ND; i++) w[4*i +: 4] = 4'(i % 10);
        send(w);
        wait_valid();
        release_out();

        // Boundary errors at digits 0 and 299
        for (int i = 0; i < ND; i++) w[4*i +: 4] = 4'd5;
        w[3:0] = 4'hA;
        w[4*(ND-1) +: 4] = 4'hF;
        send(w);
        wait_valid();
        release_out();

        // All invalid
        for (int i = 0; i < ND; i++) w[4*i +: 4] = 4'hF;
        send(w);
        wait_valid();
        release_out();

        // Single error mid-word
        for (int i = 0; i < ND; i++) w[4*i +: 4] = 4'(i % 10);
        w[4*137 +: 4] = 4'hC;
        send(w);
        wait_valid();
        release_out();

        // Backpressure with an ignored word offered during RUN
        w  = rand_word(10);
        w2 = rand_word(50);
        e  = model(w);
        send(w);
        repeat (3) @(negedge clk);
        in_bcd   = w2;
        in_valid = 1'b1;
        @(negedge clk);
        chk("in_ready_in_run", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        wait_valid();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chkdec("bp_out_dec", out_dec, e.dec);
            chk("bp_err_count", 64'(out_err_count), 64'(e.cnt));
            chk("bp_first_err", 64'(out_first_err), 64'(e.first));
        end
        release_out();

        // Reset mid-job at beat 7
        send(rand_word(20));
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        void'(q.pop_back());
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_err_count", 64'(out_err_count), 64'd0);
        chk("midrst_in_ready2", 64'(in_ready), 64'd1);
        send(rand_word(5));
        wait_valid();
        release_out();

        // Randomised jobs with random consumer stalls
        rnd_ready = 1;
        for (int j = 0; j < 40; j++) begin
            case (j % 4)
                0: send(rand_word(0));
                1: send(rand_word(2));
                2: send(rand_word(30));
                default: send(rand_word(100));
            endcase
        end
        drain(500);
        rnd_ready = 0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
